axi_rd_reorder_buffer_p: RTL and testbench
==========================================

// Module: axi_rd_reorder_buffer_p
// PURPOSE
//  Parametrised AXI read-channel reorder buffer between one upstream master (s_*) and one downstream slave (m_*).
//  Tracks up to DEPTH outstanding single-beat reads in a circular tag table.
//  Accepts R responses in any order and returns them upstream in AR-issue order.
//  Unlike the previous generation, multiple outstanding reads may share an ID, and RRESP is carried.
//  Adds an occupancy count and a sticky error flag for unexpected responses.
// PARAMETERS
//  DATA_WIDTH  8   R data width in bits
//  ID_WIDTH    4   AR/R ID width in bits
//  DEPTH       16  max outstanding reads; power of two, >= 2
// PORTS
//  clk          in   1              clock, all logic on rising edge
//  rst          in   1              synchronous, active-high reset
//  s_arid_i     in   ID_WIDTH       upstream AR ID
//  s_arvalid_i  in   1              upstream AR valid
//  s_arready_o  out  1              upstream AR ready
//  s_rdata_o    out  DATA_WIDTH     upstream R data
//  s_rid_o      out  ID_WIDTH       upstream R ID
//  s_rresp_o    out  2              upstream R response
//  s_rvalid_o   out  1              upstream R valid
//  s_rready_i   in   1              upstream R ready
//  m_arid_o     out  ID_WIDTH       downstream AR ID
//  m_arvalid_o  out  1              downstream AR valid
//  m_arready_i  in   1              downstream AR ready
//  m_rdata_i    in   DATA_WIDTH     downstream R data
//  m_rid_i      in   ID_WIDTH       downstream R ID
//  m_rresp_i    in   2              downstream R response
//  m_rvalid_i   in   1              downstream R valid
//  m_rready_o   out  1              downstream R ready
//  occupancy_o  out  $clog2(DEPTH)+1  number of allocated entries
//  err_o        out  1              sticky: R received with no matching open entry
// BEHAVIOUR
//  - Table: DEPTH entries {alloc, filled, id, data, resp}; wr_ptr/rd_ptr wrap modulo DEPTH; full = (count==DEPTH).
//  - Reset: all entries alloc=0 filled=0; pointers, count and err_o = 0.
//    While rst=1: s_arready_o=0, m_arvalid_o=0, s_rvalid_o=0, m_rready_o=0.
//  - AR path is combinational pass-through with 0 cycle latency: m_arid_o = s_arid_i.
//    m_arvalid_o = s_arvalid_i & ~full; s_arready_o = m_arready_i & ~full.
//  - Allocate on the m_ar handshake: entry[wr_ptr] <= {1,0,s_arid_i}; wr_ptr++; count++.
//  - Full blocks allocation even if a pop occurs in the same cycle.
//  - R downstream: m_rready_o = 1 whenever not in reset; every m_rvalid_i beat is consumed.
//  - Match: oldest entry (searched from rd_ptr toward wr_ptr) with alloc=1, filled=0 and id==m_rid_i.
//    On a match: store data and resp, set filled=1 at the clock edge.
//    Same-ID responses fill in issue order.
//  - No match: beat is dropped, table unchanged, err_o <= 1 (stays set until rst).
//  - Upstream R outputs are driven directly from entry[rd_ptr]:
//    s_rvalid_o = alloc & filled; s_rid_o, s_rdata_o and s_rresp_o come from that entry.
//    Minimum latency is 1 cycle from the m_r handshake to s_rvalid_o.
//  - Pop on s_rvalid_o & s_rready_i: entry[rd_ptr].alloc <= 0, filled <= 0; rd_ptr++; count--.
//  - Simultaneous allocate and pop: count unchanged; both pointers advance.
//  - Simultaneous fill of entry X and pop of head Y != X: both take effect.
//    A fill of the head becomes visible on the next cycle.
//  - s_rvalid_o is held with stable payload until s_rready_i (AXI rule); it never drops without a handshake.
//  - Reset mid-operation discards all entries.
//    Responses arriving after reset for pre-reset requests are unmatched and set err_o.
// TESTING
//  - In order: AR ids 1,2,3 accepted; R id1/0x11, id2/0x22, id3/0x33 on consecutive cycles
//    -> s_r emits (1,0x11),(2,0x22),(3,0x33), first one cycle after id1 return.
//  - Out of order: AR 5,7,9; R returns 9/0xCC, 7/0xBB, 5/0xAA
//    -> no s_rvalid_o until id5 arrives, then 5/0xAA, 7/0xBB, 9/0xCC back to back; resp passes through (e.g. id7 resp=2'b10).
//  - Duplicate IDs: AR 3,3; R id3/0x11 then id3/0x22 -> output 0x11 then 0x22; occupancy_o goes 2,1,0.
//  - Full (DEPTH=4): 4 ARs accepted, 5th held with s_arready_o=0, m_arvalid_o=0, occupancy_o=4.
//    First pop lets the 5th through on the next cycle.
//  - Backpressure: head filled, s_rready_i=0 for 10 cycles -> s_rvalid_o=1 with payload stable.
//    Further fills still accepted (m_rready_o=1).
//  - Errors and reset: R id 0xF with no open entry -> err_o=1 next cycle, occupancy unchanged.
//    rst pulse with 3 entries open -> occupancy_o=0, err_o=0, s_rvalid_o=0.

Source files
------------

// File: rtl/axi_rd_reorder_buffer_p.sv
// AXI read-channel reorder buffer.
// Single-beat reads are tracked in a circular tag table in AR-issue order.
// Downstream R beats may come back in any order; each beat is matched to the
// oldest open entry with the same ID, so reads that share an ID are filled in
// the order they were issued. Upstream R beats leave strictly from the head
// of the table, which gives the original AR order back to the master.
// A beat that matches no open entry is dropped and sets a sticky error flag.
//
// state of one table entry (alloc, filled):
//   alloc filled | meaning
//   0     0      | free
//   1     0      | AR issued downstream, waiting for its R beat
//   1     1      | R beat captured, waiting to be returned upstream
module axi_rd_reorder_buffer_p #(
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 4,
  parameter int DEPTH      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ID_WIDTH-1:0]        s_arid_i,
  input  logic                       s_arvalid_i,
  output logic                       s_arready_o,
  output logic [DATA_WIDTH-1:0]      s_rdata_o,
  output logic [ID_WIDTH-1:0]        s_rid_o,
  output logic [1:0]                 s_rresp_o,
  output logic                       s_rvalid_o,
  input  logic                       s_rready_i,
  output logic [ID_WIDTH-1:0]        m_arid_o,
  output logic                       m_arvalid_o,
  input  logic                       m_arready_i,
  input  logic [DATA_WIDTH-1:0]      m_rdata_i,
  input  logic [ID_WIDTH-1:0]        m_rid_i,
  input  logic [1:0]                 m_rresp_i,
  input  logic                       m_rvalid_i,
  output logic                       m_rready_o,
  output logic [$clog2(DEPTH):0]     occupancy_o,
  output logic                       err_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0]      alloc_q;
  logic [DEPTH-1:0]      filled_q;
  logic [ID_WIDTH-1:0]   id_q   [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [1:0]            resp_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             err_q;

  logic             full;
  logic             ar_fire;
  logic             r_fire;
  logic             pop;
  logic             match_hit;
  logic [PTR_W-1:0] match_idx;
  logic [PTR_W-1:0] scan_idx;

  // Full is taken from the registered count, so a pop in the same cycle
  // cannot open a slot for an AR until the following cycle.
  assign full = (count == CNT_W'(DEPTH));

  assign m_arid_o    = s_arid_i;
  assign m_arvalid_o = s_arvalid_i & ~full & ~rst;
  assign s_arready_o = m_arready_i & ~full & ~rst;
  assign ar_fire     = m_arvalid_o & m_arready_i;

  // Every downstream beat is accepted; unmatched ones are simply dropped.
  assign m_rready_o = ~rst;
  assign r_fire     = m_rvalid_i & m_rready_o;

  // Upstream R is driven straight from the head entry, so the payload stays
  // stable for as long as the head is not popped.
  assign s_rvalid_o = alloc_q[rd_ptr] & filled_q[rd_ptr] & ~rst;
  assign s_rid_o    = id_q[rd_ptr];
  assign s_rdata_o  = data_q[rd_ptr];
  assign s_rresp_o  = resp_q[rd_ptr];
  assign pop        = s_rvalid_o & s_rready_i;

  assign occupancy_o = count;
  assign err_o       = err_q;

  // Find the oldest waiting entry for the returning ID, scanning from the head.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    scan_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = rd_ptr + PTR_W'(i);
      if (!match_hit && alloc_q[scan_idx] && !filled_q[scan_idx] &&
          (id_q[scan_idx] == m_rid_i)) begin
        match_hit = 1'b1;
        match_idx = scan_idx;
      end
    end
  end

  // Entry state bits: free on pop, filled on match, allocated on AR handshake.
  // A fill never targets the head being popped (that one is already filled),
  // and an allocation never lands on an allocated slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_q  <= '0;
      filled_q <= '0;
    end else begin
      if (pop) begin
        alloc_q[rd_ptr]  <= 1'b0;
        filled_q[rd_ptr] <= 1'b0;
      end
      if (r_fire && match_hit) begin
        filled_q[match_idx] <= 1'b1;
      end
      if (ar_fire) begin
        alloc_q[wr_ptr]  <= 1'b1;
        filled_q[wr_ptr] <= 1'b0;
      end
    end
  end

  // Entry payload; only meaningful while the matching state bits say so.
  always_ff @(posedge clk) begin
    if (ar_fire) begin
      id_q[wr_ptr] <= s_arid_i;
    end
    if (r_fire && match_hit) begin
      data_q[match_idx] <= m_rdata_i;
      resp_q[match_idx] <= m_rresp_i;
    end
  end

  // Circular pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (ar_fire) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({ar_fire, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky flag for downstream beats that found no open entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (r_fire && !match_hit) begin
      err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_rd_reorder_buffer_p.sv
// Directed bench for the read reorder buffer, built with DEPTH=4 so the
// full condition and pointer wrap are reached with short sequences.
module tb_axi_rd_reorder_buffer_p;

  localparam int DW = 8;
  localparam int IW = 4;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] s_arid_i;
  logic          s_arvalid_i;
  logic          s_arready_o;
  logic [DW-1:0] s_rdata_o;
  logic [IW-1:0] s_rid_o;
  logic [1:0]    s_rresp_o;
  logic          s_rvalid_o;
  logic          s_rready_i;
  logic [IW-1:0] m_arid_o;
  logic          m_arvalid_o;
  logic          m_arready_i;
  logic [DW-1:0] m_rdata_i;
  logic [IW-1:0] m_rid_i;
  logic [1:0]    m_rresp_i;
  logic          m_rvalid_i;
  logic          m_rready_o;
  logic [2:0]    occupancy_o;
  logic          err_o;

  int n_cmp = 0;
  int n_err = 0;

  axi_rd_reorder_buffer_p #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_arid_i(s_arid_i), .s_arvalid_i(s_arvalid_i), .s_arready_o(s_arready_o),
    .s_rdata_o(s_rdata_o), .s_rid_o(s_rid_o), .s_rresp_o(s_rresp_o),
    .s_rvalid_o(s_rvalid_o), .s_rready_i(s_rready_i),
    .m_arid_o(m_arid_o), .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i),
    .m_rdata_i(m_rdata_i), .m_rid_i(m_rid_i), .m_rresp_i(m_rresp_i),
    .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o),
    .occupancy_o(occupancy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ar(input logic [IW-1:0] id);
    s_arid_i    = id;
    s_arvalid_i = 1'b1;
    step();
    s_arvalid_i = 1'b0;
  endtask

  task automatic drive_r(input logic [IW-1:0] id, input logic [DW-1:0] d, input logic [1:0] rsp);
    m_rid_i    = id;
    m_rdata_i  = d;
    m_rresp_i  = rsp;
    m_rvalid_i = 1'b1;
  endtask

  task automatic idle_r();
    m_rvalid_i = 1'b0;
  endtask

  logic stable;

  initial begin
    rst = 1'b1;
    s_arid_i = 4'h1; s_arvalid_i = 1'b1; m_arready_i = 1'b1; s_rready_i = 1'b0;
    m_rid_i = '0; m_rdata_i = '0; m_rresp_i = '0; m_rvalid_i = 1'b0;
    step();
    check("rst_s_arready", s_arready_o, 0);
    check("rst_m_arvalid", m_arvalid_o, 0);
    check("rst_m_rready", m_rready_o, 0);
    check("rst_s_rvalid", s_rvalid_o, 0);
    step();
    s_arvalid_i = 1'b0;
    rst = 1'b0;
    step();
    check("rst_occ", occupancy_o, 0);
    check("rst_err", err_o, 0);
    check("m_rready_on", m_rready_o, 1);

    // in order
    s_rready_i = 1'b1;
    ar(4'h1); ar(4'h2); ar(4'h3);
    check("io_occ3", occupancy_o, 3);
    drive_r(4'h1, 8'h11, 2'b00);
    #1 check("io_no_early", s_rvalid_o, 0);
    step();
    check("io1_valid", s_rvalid_o, 1);
    check("io1_id", s_rid_o, 1);
    check("io1_data", s_rdata_o, 8'h11);
    drive_r(4'h2, 8'h22, 2'b00);
    step();
    check("io2_id", s_rid_o, 2);
    check("io2_data", s_rdata_o, 8'h22);
    drive_r(4'h3, 8'h33, 2'b00);
    step();
    check("io3_id", s_rid_o, 3);
    check("io3_data", s_rdata_o, 8'h33);
    idle_r();
    step();
    check("io_done_valid", s_rvalid_o, 0);
    check("io_done_occ", occupancy_o, 0);

    // out of order, pointers wrap across the table end
    ar(4'h5); ar(4'h7); ar(4'h9);
    drive_r(4'h9, 8'hCC, 2'b00);
    step();
    check("ooo_hold1", s_rvalid_o, 0);
    drive_r(4'h7, 8'hBB, 2'b10);
    step();
    check("ooo_hold2", s_rvalid_o, 0);
    drive_r(4'h5, 8'hAA, 2'b00);
    step();
    idle_r();
    check("ooo5_valid", s_rvalid_o, 1);
    check("ooo5", {s_rid_o, s_rdata_o}, {4'h5, 8'hAA});
    step();
    check("ooo7", {s_rid_o, s_rdata_o}, {4'h7, 8'hBB});
    check("ooo7_resp", s_rresp_o, 2'b10);
    check("ooo7_valid", s_rvalid_o, 1);
    step();
    check("ooo9", {s_rid_o, s_rdata_o}, {4'h9, 8'hCC});
    step();
    check("ooo_done", s_rvalid_o, 0);

    // duplicate IDs fill in issue order
    s_rready_i = 1'b0;
    ar(4'h3); ar(4'h3);
    drive_r(4'h3, 8'h11, 2'b00);
    step();
    drive_r(4'h3, 8'h22, 2'b01);
    step();
    idle_r();
    check("dup_occ2", occupancy_o, 2);
    check("dup_first", s_rdata_o, 8'h11);
    s_rready_i = 1'b1;
    step();
    check("dup_occ1", occupancy_o, 1);
    check("dup_second", s_rdata_o, 8'h22);
    check("dup_second_resp", s_rresp_o, 2'b01);
    step();
    check("dup_occ0", occupancy_o, 0);
    check("dup_empty", s_rvalid_o, 0);

    // full
    s_rready_i = 1'b0;
    ar(4'h1); ar(4'h2); ar(4'h3); ar(4'h4);
    check("full_occ4", occupancy_o, 4);
    s_arid_i = 4'h5; s_arvalid_i = 1'b1;
    #1;
    check("full_s_arready", s_arready_o, 0);
    check("full_m_arvalid", m_arvalid_o, 0);
    check("full_m_arid", m_arid_o, 5);
    drive_r(4'h1, 8'h55, 2'b00);
    step();
    idle_r();
    check("full_held_occ", occupancy_o, 4);
    s_rready_i = 1'b1;
    step();
    s_rready_i = 1'b0;
    check("full_pop_occ", occupancy_o, 3);
    check("full_released", m_arvalid_o, 1);
    step();
    s_arvalid_i = 1'b0;
    check("full_refill_occ", occupancy_o, 4);

    // backpressure: head id2 filled, upstream stalled for 10 cycles
    drive_r(4'h2, 8'h77, 2'b01);
    step();
    idle_r();
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!(s_rvalid_o && s_rid_o == 4'h2 && s_rdata_o == 8'h77 && s_rresp_o == 2'b01))
        stable = 1'b0;
      if (i == 3) begin
        check("bp_m_rready", m_rready_o, 1);
        drive_r(4'h4, 8'h44, 2'b00);
      end
      step();
      idle_r();
    end
    check("bp_stable", stable, 1);
    check("bp_occ", occupancy_o, 4);
    s_rready_i = 1'b1;
    step();
    s_rready_i = 1'b0;
    check("bp_head3_unfilled", s_rvalid_o, 0);
    check("bp_occ3", occupancy_o, 3);

    // unmatched response
    drive_r(4'hF, 8'hEE, 2'b00);
    step();
    idle_r();
    check("err_set", err_o, 1);
    check("err_occ", occupancy_o, 3);

    // reset with 3 entries open
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2_occ", occupancy_o, 0);
    check("rst2_err", err_o, 0);
    check("rst2_valid", s_rvalid_o, 0);
    drive_r(4'h3, 8'h99, 2'b00);
    step();
    idle_r();
    check("stale_err", err_o, 1);
    check("stale_valid", s_rvalid_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
